// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: parses PS/2 scan bytes into make/break key events,
// buffers them in a first-word fall-through FIFO, tracks the held key and
// a wrapping press counter, and drives hex seven-segment patterns.
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_code_valid, i_code   one-cycle strobe with received scan byte
//   i_evt_ready            consumer accepts the head event
//   o_evt_valid/o_evt_data head event {ext, brk, code}
//   o_evt_overflow         sticky: event dropped on full FIFO
//   o_held/o_held_code     currently held key {ext, code}
//   o_press_count          wrapping press counter
//   o_seg_code/o_seg_count seven-segment digits {dp,g,f,e,d,c,b,a}
module ps2_key_tracker #(
  parameter int CNT_W          = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int COUNT_REPEAT   = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_code_valid,
  input  logic [7:0]                     i_code,
  input  logic                           i_evt_ready,
  output logic                           o_evt_valid,
  output logic [9:0]                     o_evt_data,
  output logic                           o_evt_overflow,
  output logic                           o_held,
  output logic [8:0]                     o_held_code,
  output logic [CNT_W-1:0]               o_press_count,
  output logic [15:0]                    o_seg_code,
  output logic [8*((CNT_W+3)/4)-1:0]     o_seg_count
);

  localparam int NDIG = (CNT_W + 3) / 4;
  localparam int PADW = 4 * NDIG;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;
  localparam bit DROP_REPEAT = (COUNT_REPEAT == 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_held;
  logic [8:0]       r_held_code;
  logic [CNT_W-1:0] r_press_count;
  logic             r_overflow;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [9:0]       r_mem [FIFO_DEPTH];

  logic       w_prefix_or_junk;
  logic       w_fire;
  logic       w_ext;
  logic       w_brk;
  logic [8:0] w_key;
  logic       w_key_match;
  logic       w_make;
  logic       w_push;
  logic       w_release;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_wr;
  logic [PADW-1:0] w_cnt_pad;

  // Event decode for the byte presented this cycle
  always_comb begin
    w_prefix_or_junk = (i_code == 8'hE0) || (i_code == 8'hF0) ||
                       (i_code == 8'h00) || (i_code == 8'hFF);
    w_fire      = i_code_valid && !w_prefix_or_junk;
    w_ext       = (r_state == S_EXT) || (r_state == S_EXT_BRK);
    w_brk       = (r_state == S_BRK) || (r_state == S_EXT_BRK);
    w_key       = {w_ext, i_code};
    w_key_match = r_held && (r_held_code == w_key);
    w_make      = w_fire && !w_brk && !(w_key_match && DROP_REPEAT);
    w_push      = w_make || (w_fire && w_brk);
    w_release   = w_fire && w_brk && w_key_match;
  end

  // FIFO status: pointers carry one extra wrap bit
  always_comb begin
    w_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[AW] != r_rptr[AW]) &&
              (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    w_pop   = !w_empty && i_evt_ready;
    w_wr    = w_push && (!w_full || w_pop);
  end

  // Parser FSM with key state and counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_held        <= 1'b0;
      r_held_code   <= '0;
      r_press_count <= '0;
    end else begin
      if (i_code_valid) begin
        case (i_code)
          8'hE0: r_state <= S_EXT;
          8'hF0: begin
            case (r_state)
              S_IDLE:  r_state <= S_BRK;
              S_EXT:   r_state <= S_EXT_BRK;
              default: r_state <= r_state;
            endcase
          end
          default: r_state <= S_IDLE;
        endcase
      end
      if (w_make) begin
        r_held        <= 1'b1;
        r_held_code   <= w_key;
        r_press_count <= r_press_count + CNT_W'(1);
      end else if (w_release) begin
        r_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      if (w_push && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_mem[r_wptr[AW-1:0]] <= {w_ext, w_brk, i_code};
  end

  // Glyph table is active-low; active-high output is its inverse
  function automatic logic [7:0] seg_glyph(input logic blank, input logic [3:0] n);
    logic [7:0] v;
    case (n)
      4'h0: v = 8'hC0;
      4'h1: v = 8'hF9;
      4'h2: v = 8'hA4;
      4'h3: v = 8'hB0;
      4'h4: v = 8'h99;
      4'h5: v = 8'h92;
      4'h6: v = 8'h82;
      4'h7: v = 8'hF8;
      4'h8: v = 8'h80;
      4'h9: v = 8'h90;
      4'hA: v = 8'h88;
      4'hB: v = 8'h83;
      4'hC: v = 8'hC6;
      4'hD: v = 8'hA1;
      4'hE: v = 8'h86;
      default: v = 8'h8E;
    endcase
    if (blank)
      v = 8'hFF;
    return (SEG_ACTIVE_LOW != 0) ? v : ~v;
  endfunction

  assign w_cnt_pad = PADW'(r_press_count);

  always_comb begin
    o_seg_code  = {seg_glyph(!r_held, r_held_code[7:4]),
                   seg_glyph(!r_held, r_held_code[3:0])};
    o_seg_count = '0;
    for (int unsigned i = 0; i < NDIG; i++)
      o_seg_count[8*i +: 8] = seg_glyph(1'b0, w_cnt_pad[4*i +: 4]);
  end

  assign o_evt_valid    = !w_empty;
  assign o_evt_data     = r_mem[r_rptr[AW-1:0]];
  assign o_evt_overflow = r_overflow;
  assign o_held         = r_held;
  assign o_held_code    = r_held_code;
  assign o_press_count  = r_press_count;

endmodule
